// File: rtl/sys_csr_bank.sv
// ----------------------------------------------------------------------------
// sys_csr_bank
// Responder end of the simple RP system bus. It decodes one-cycle
// read/write requests from the AXI-to-sys bridge. Each request gets exactly
// one acknowledge. The bank holds NCTRL writable control words that drive the
// DSP core, and it returns NSTAT read-only status words.
//
// Optional feature macro: SYS_CSR_SHADOW_EN
//   undefined : bus writes update ctrl_o directly and commit_i is ignored.
//   defined   : bus writes land in shadow registers, and reads of ctrl words
//               return the shadow. ctrl_o loads every shadow at once in the
//               cycle after commit_i=1. This includes a write made in the
//               same cycle as the commit.
//
// Ports
//   sys_clk_i    clock
//   sys_rst_i    synchronous active-high reset
//   sys_addr_i   byte address; the word index is sys_addr_i[11:2]
//   sys_wdata_i  write data (sampled with sys_wen_i)
//   sys_sel_i    byte-lane enables for writes
//   sys_wen_i    one-cycle write request
//   sys_ren_i    one-cycle read request
//   sys_rdata_o  read data; zero unless sys_ack_o=1
//   sys_err_o    error flag; meaningful with sys_ack_o=1
//   sys_ack_o    one-cycle acknowledge
//   ctrl_o       control word k at [k*DW +: DW]
//   ctrl_wstb_o  bit k pulses for one cycle when ctrl word k is written
//   stat_i       status word s at [s*DW +: DW]
//   commit_i     shadow commit strobe (used only with SYS_CSR_SHADOW_EN)
// ----------------------------------------------------------------------------
module sys_csr_bank #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int SW     = DW / 8,
    parameter int NCTRL  = 8,
    parameter int NSTAT  = 4,
    parameter int RD_LAT = 2
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rst_i,
    input  logic [AW-1:0]         sys_addr_i,
    input  logic [DW-1:0]         sys_wdata_i,
    input  logic [SW-1:0]         sys_sel_i,
    input  logic                  sys_wen_i,
    input  logic                  sys_ren_i,
    output logic [DW-1:0]         sys_rdata_o,
    output logic                  sys_err_o,
    output logic                  sys_ack_o,
    output logic [NCTRL*DW-1:0]   ctrl_o,
    output logic [NCTRL-1:0]      ctrl_wstb_o,
    input  logic [NSTAT*DW-1:0]   stat_i,
    input  logic                  commit_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WACK  = 2'd1,
        ST_RWAIT = 2'd2
    } state_t;

    localparam logic [10:0] LP_NCTRL   = 11'(NCTRL);
    localparam logic [10:0] LP_NMAP    = 11'(NCTRL + NSTAT);
    localparam logic [3:0]  LP_LAT_M1  = 4'(RD_LAT - 1);
    localparam bit          LP_LAT_ONE = (RD_LAT == 1);

    // Byte-lane merge: lanes with sel=1 take the new data.
    function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] old_w,
                                              input logic [DW-1:0] new_w,
                                              input logic [SW-1:0] sel);
        logic [DW-1:0] res;
        res = old_w;
        for (int b = 0; b < SW; b++) begin
            res[b*8 +: 8] = sel[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
        end
        return res;
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_ack, w_ack_nxt;
    logic                r_err, w_err_nxt;
    logic [DW-1:0]       r_rdata, w_rdata_nxt;
    logic [NCTRL-1:0]    r_wstb, w_wstb_nxt;
    logic [3:0]          r_cnt, w_cnt_nxt;
    logic [DW-1:0]       r_hold, w_hold_nxt;
    logic                r_hold_err, w_hold_err_nxt;
    logic                w_wr_ctrl;

    // r_src is the bus-visible copy of each ctrl word. It is the live
    // ctrl register or the shadow, depending on the build.
    logic [DW-1:0]       r_src [NCTRL];
    logic [DW-1:0]       w_src_nxt [NCTRL];

    logic [9:0]          w_idx;
    logic [10:0]         w_idx_ext;
    logic                w_is_ctrl;
    logic                w_is_stat;
    logic [NCTRL-1:0]    w_idx_onehot;
    logic [DW-1:0]       w_rd_word;

    assign w_idx     = sys_addr_i[11:2];
    assign w_idx_ext = {1'b0, w_idx};
    assign w_is_ctrl = (w_idx_ext < LP_NCTRL);
    assign w_is_stat = (w_idx_ext >= LP_NCTRL) && (w_idx_ext < LP_NMAP);

    // One-hot ctrl word select and read-data mux. Unmapped indices yield 0.
    always_comb begin
        w_idx_onehot = {NCTRL{1'b0}};
        w_rd_word    = {DW{1'b0}};
        for (int k = 0; k < NCTRL; k++) begin
            w_idx_onehot[k] = (w_idx == 10'(k));
            w_rd_word       = w_rd_word | ({DW{w_idx == 10'(k)}} & r_src[k]);
        end
        for (int s = 0; s < NSTAT; s++) begin
            w_rd_word = w_rd_word |
                        ({DW{w_idx == 10'(NCTRL + s)}} & stat_i[s*DW +: DW]);
        end
    end

    // Next value of each bus-visible ctrl word, with this cycle's write merged in.
    always_comb begin
        for (int k = 0; k < NCTRL; k++) begin
            w_src_nxt[k] = (w_wr_ctrl && w_idx_onehot[k]) ?
                           f_merge(r_src[k], sys_wdata_i, sys_sel_i) : r_src[k];
        end
    end

    // Next-state and registered-output logic of the request FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_ack_nxt      = 1'b0;
        w_err_nxt      = 1'b0;
        w_rdata_nxt    = {DW{1'b0}};
        w_wstb_nxt     = {NCTRL{1'b0}};
        w_cnt_nxt      = r_cnt;
        w_hold_nxt     = r_hold;
        w_hold_err_nxt = r_hold_err;
        w_wr_ctrl      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (sys_wen_i) begin
                    // A write takes priority over a read in the same cycle.
                    w_state_nxt = ST_WACK;
                    w_ack_nxt   = 1'b1;
                    w_err_nxt   = ~w_is_ctrl;
                    w_wr_ctrl   = w_is_ctrl;
                    w_wstb_nxt  = w_is_ctrl ? w_idx_onehot : {NCTRL{1'b0}};
                end else if (sys_ren_i) begin
                    // Snapshot the word now so later stat_i changes cannot leak in.
                    w_state_nxt    = ST_RWAIT;
                    w_hold_nxt     = w_rd_word;
                    w_hold_err_nxt = ~(w_is_ctrl | w_is_stat);
                    w_cnt_nxt      = LP_LAT_M1;
                    if (LP_LAT_ONE) begin
                        w_ack_nxt   = 1'b1;
                        w_rdata_nxt = w_rd_word;
                        w_err_nxt   = ~(w_is_ctrl | w_is_stat);
                    end else begin
                        w_ack_nxt   = 1'b0;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WACK: begin
                // This is the ack cycle. Requests arriving now are dropped.
                w_state_nxt = ST_IDLE;
            end
            ST_RWAIT: begin
                if (r_ack) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_ack_nxt   = 1'b1;
                        w_rdata_nxt = r_hold;
                        w_err_nxt   = r_hold_err;
                    end else begin
                        w_ack_nxt   = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state and bus response registers.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_state    <= ST_IDLE;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= {DW{1'b0}};
            r_wstb     <= {NCTRL{1'b0}};
            r_cnt      <= 4'd0;
            r_hold     <= {DW{1'b0}};
            r_hold_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ack      <= w_ack_nxt;
            r_err      <= w_err_nxt;
            r_rdata    <= w_rdata_nxt;
            r_wstb     <= w_wstb_nxt;
            r_cnt      <= w_cnt_nxt;
            r_hold     <= w_hold_nxt;
            r_hold_err <= w_hold_err_nxt;
        end
    end

    // Bus-visible ctrl words (live ctrl or shadow).
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            for (int k = 0; k < NCTRL; k++) begin
                r_src[k] <= {DW{1'b0}};
            end
        end else begin
            for (int k = 0; k < NCTRL; k++) begin
                r_src[k] <= w_src_nxt[k];
            end
        end
    end

`ifdef SYS_CSR_SHADOW_EN
    logic [DW-1:0] r_ctrl [NCTRL];

    // Live ctrl words load every shadow together on commit. The load uses
    // the post-write shadow value, so a write in the commit cycle is included.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            for (int k = 0; k < NCTRL; k++) begin
                r_ctrl[k] <= {DW{1'b0}};
            end
        end else if (commit_i) begin
            for (int k = 0; k < NCTRL; k++) begin
                r_ctrl[k] <= w_src_nxt[k];
            end
        end else begin
            for (int k = 0; k < NCTRL; k++) begin
                r_ctrl[k] <= r_ctrl[k];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NCTRL; g++) begin : g_ctrl_out
            assign ctrl_o[g*DW +: DW] = r_ctrl[g];
        end
    endgenerate

    logic w_unused_addr;
    assign w_unused_addr = ^{sys_addr_i[AW-1:12], sys_addr_i[1:0]};
`else
    genvar g;
    generate
        for (g = 0; g < NCTRL; g++) begin : g_ctrl_out
            assign ctrl_o[g*DW +: DW] = r_src[g];
        end
    endgenerate

    logic w_unused_addr;
    assign w_unused_addr = ^{sys_addr_i[AW-1:12], sys_addr_i[1:0], commit_i};
`endif

    assign sys_ack_o   = r_ack;
    assign sys_err_o   = r_err;
    assign sys_rdata_o = r_rdata;
    assign ctrl_wstb_o = r_wstb;

endmodule

// File: tb/tb_sys_csr_bank.sv
// ----------------------------------------------------------------------------
// tb_sys_csr_bank
// Directed testbench for sys_csr_bank with default parameters
// (NCTRL=8, NSTAT=4, RD_LAT=2). Inputs are driven 1 time unit after each
// rising edge. Outputs are checked at the same point.
// ----------------------------------------------------------------------------
module tb_sys_csr_bank;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int NCTRL = 8;
    localparam int NSTAT = 4;
    localparam int RD_LAT = 2;

`ifdef SYS_CSR_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic                sys_clk_i = 1'b0;
    logic                sys_rst_i;
    logic [AW-1:0]       sys_addr_i;
    logic [DW-1:0]       sys_wdata_i;
    logic [SW-1:0]       sys_sel_i;
    logic                sys_wen_i;
    logic                sys_ren_i;
    logic [DW-1:0]       sys_rdata_o;
    logic                sys_err_o;
    logic                sys_ack_o;
    logic [NCTRL*DW-1:0] ctrl_o;
    logic [NCTRL-1:0]    ctrl_wstb_o;
    logic [NSTAT*DW-1:0] stat_i;
    logic                commit_i;

    int n_cmp = 0;
    int n_bad = 0;

    sys_csr_bank #(
        .AW(AW), .DW(DW), .SW(SW), .NCTRL(NCTRL), .NSTAT(NSTAT), .RD_LAT(RD_LAT)
    ) dut (
        .sys_clk_i   (sys_clk_i),
        .sys_rst_i   (sys_rst_i),
        .sys_addr_i  (sys_addr_i),
        .sys_wdata_i (sys_wdata_i),
        .sys_sel_i   (sys_sel_i),
        .sys_wen_i   (sys_wen_i),
        .sys_ren_i   (sys_ren_i),
        .sys_rdata_o (sys_rdata_o),
        .sys_err_o   (sys_err_o),
        .sys_ack_o   (sys_ack_o),
        .ctrl_o      (ctrl_o),
        .ctrl_wstb_o (ctrl_wstb_o),
        .stat_i      (stat_i),
        .commit_i    (commit_i)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    task automatic tick();
        @(posedge sys_clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] word_of(input logic [NCTRL*DW-1:0] v, input int k);
        return v[k*DW +: DW];
    endfunction

    initial begin
        logic [NCTRL*DW-1:0] exp_ctrl;
        int acks;

        sys_rst_i   = 1'b1;
        sys_addr_i  = 32'h0;
        sys_wdata_i = 32'h0;
        sys_sel_i   = 4'h0;
        sys_wen_i   = 1'b0;
        sys_ren_i   = 1'b0;
        commit_i    = 1'b0;
        stat_i      = {NSTAT*DW{1'b0}};
        stat_i[1*DW +: DW] = 32'hDEAD_BEEF;
        tick();
        tick();
        sys_rst_i = 1'b0;

        // Reset state
        check("rst_ack", sys_ack_o, 1'b0);
        check("rst_rdata", sys_rdata_o, 32'h0);
        check("rst_wstb", ctrl_wstb_o, 8'h0);
        check("rst_ctrl", ctrl_o, 256'h0);

        // Partial-lane write to ctrl word 3
        sys_wen_i = 1'b1; sys_addr_i = 32'd12; sys_wdata_i = 32'hA5A5_1234; sys_sel_i = 4'b0011;
        tick();
        sys_wen_i = 1'b0;
        check("wr3_ack", sys_ack_o, 1'b1);
        check("wr3_err", sys_err_o, 1'b0);
        check("wr3_wstb", ctrl_wstb_o, 8'b0000_1000);
        check("wr3_ctrl", word_of(ctrl_o, 3), SHADOW ? 32'h0 : 32'h0000_1234);
        tick();
        check("wr3_ack_drop", sys_ack_o, 1'b0);
        check("wr3_wstb_drop", ctrl_wstb_o, 8'h0);

        // Read ctrl word 3: the ack must arrive exactly RD_LAT=2 cycles later
        sys_ren_i = 1'b1; sys_addr_i = 32'd12;
        tick();
        sys_ren_i = 1'b0;
        check("rd3_early", sys_ack_o, 1'b0);
        tick();
        check("rd3_ack", sys_ack_o, 1'b1);
        check("rd3_data", sys_rdata_o, 32'h0000_1234);
        check("rd3_err", sys_err_o, 1'b0);
        tick();
        check("rd3_ack_drop", sys_ack_o, 1'b0);
        check("rd3_data_zero", sys_rdata_o, 32'h0);

        // Stat snapshot: stat_i changes after the request is sampled
        sys_ren_i = 1'b1; sys_addr_i = 32'((NCTRL + 1) * 4);
        tick();
        sys_ren_i = 1'b0;
        stat_i[1*DW +: DW] = 32'h0;
        tick();
        check("rdstat_ack", sys_ack_o, 1'b1);
        check("rdstat_data", sys_rdata_o, 32'hDEAD_BEEF);
        check("rdstat_err", sys_err_o, 1'b0);
        tick();

        // Write to a stat word: the bank flags an error and leaves ctrl unchanged
        exp_ctrl = {NCTRL*DW{1'b0}};
        exp_ctrl[3*DW +: DW] = SHADOW ? 32'h0 : 32'h0000_1234;
        sys_wen_i = 1'b1; sys_addr_i = 32'(NCTRL * 4); sys_wdata_i = 32'hFFFF_FFFF; sys_sel_i = 4'hF;
        tick();
        sys_wen_i = 1'b0;
        check("wrstat_ack", sys_ack_o, 1'b1);
        check("wrstat_err", sys_err_o, 1'b1);
        check("wrstat_wstb", ctrl_wstb_o, 8'h0);
        check("wrstat_ctrl", ctrl_o, exp_ctrl);
        tick();

        // Read from unmapped index 1023
        sys_ren_i = 1'b1; sys_addr_i = 32'h0000_0FFC;
        tick();
        sys_ren_i = 1'b0;
        check("rdunm_early", sys_ack_o, 1'b0);
        tick();
        check("rdunm_ack", sys_ack_o, 1'b1);
        check("rdunm_err", sys_err_o, 1'b1);
        check("rdunm_data", sys_rdata_o, 32'h0);
        tick();

        // Write and read in the same cycle, then a read during WACK
        sys_wen_i = 1'b1; sys_ren_i = 1'b1; sys_addr_i = 32'd0; sys_wdata_i = 32'h0000_0011; sys_sel_i = 4'b0001;
        tick();
        sys_wen_i = 1'b0; sys_ren_i = 1'b1; sys_addr_i = 32'd12;
        check("wr_rd_ack", sys_ack_o, 1'b1);
        check("wr_rd_err", sys_err_o, 1'b0);
        check("wr_rd_wstb", ctrl_wstb_o, 8'b0000_0001);
        tick();
        sys_ren_i = 1'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            if (sys_ack_o) acks++;
            tick();
        end
        check("dropped_reads", acks, 0);

        // Read back word 0 (returns the shadow value in shadow builds)
        sys_ren_i = 1'b1; sys_addr_i = 32'd0;
        tick();
        sys_ren_i = 1'b0;
        tick();
        check("rd0_ack", sys_ack_o, 1'b1);
        check("rd0_data", sys_rdata_o, 32'h0000_0011);
        tick();

        // sel=0 on a ctrl word: the strobe still pulses, data is unchanged
        sys_wen_i = 1'b1; sys_addr_i = 32'd8; sys_wdata_i = 32'hFFFF_FFFF; sys_sel_i = 4'b0000;
        tick();
        sys_wen_i = 1'b0;
        check("sel0_ack", sys_ack_o, 1'b1);
        check("sel0_err", sys_err_o, 1'b0);
        check("sel0_wstb", ctrl_wstb_o, 8'b0000_0100);
        check("sel0_ctrl", word_of(ctrl_o, 2), 32'h0);
        tick();

        // Back-to-back writes: the second is issued in the cycle after the ack
        sys_wen_i = 1'b1; sys_addr_i = 32'd20; sys_wdata_i = 32'hCAFE_5678; sys_sel_i = 4'b1100;
        tick();
        sys_wen_i = 1'b0;
        check("b2b_ack1", sys_ack_o, 1'b1);
        tick();
        sys_wen_i = 1'b1; sys_addr_i = 32'd24; sys_wdata_i = 32'h1357_9BDF; sys_sel_i = 4'b1111;
        tick();
        sys_wen_i = 1'b0;
        check("b2b_ack2", sys_ack_o, 1'b1);
        check("b2b_wstb2", ctrl_wstb_o, 8'b0100_0000);
        check("b2b_ctrl5", word_of(ctrl_o, 5), SHADOW ? 32'h0 : 32'hCAFE_0000);
        check("b2b_ctrl6", word_of(ctrl_o, 6), SHADOW ? 32'h0 : 32'h1357_9BDF);
        tick();

        // Reset while in RWAIT: the pending ack is never issued
        sys_ren_i = 1'b1; sys_addr_i = 32'd12;
        tick();
        sys_ren_i = 1'b0;
        sys_rst_i = 1'b1;
        tick();
        sys_rst_i = 1'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            if (sys_ack_o) acks++;
            tick();
        end
        check("rst_rwait_noack", acks, 0);
        check("rst_rwait_ctrl", ctrl_o, 256'h0);
        check("rst_rwait_rdata", sys_rdata_o, 32'h0);

`ifdef SYS_CSR_SHADOW_EN
        // Shadow: ctrl_o waits for commit_i
        sys_wen_i = 1'b1; sys_addr_i = 32'd0; sys_wdata_i = 32'h0000_0055; sys_sel_i = 4'b0001;
        tick();
        sys_wen_i = 1'b0;
        check("sh_precommit0", word_of(ctrl_o, 0), 32'h0);
        tick();
        tick();
        check("sh_precommit1", word_of(ctrl_o, 0), 32'h0);
        commit_i = 1'b1;
        tick();
        commit_i = 1'b0;
        check("sh_commit0", word_of(ctrl_o, 0), 32'h0000_0055);
        // A write in the commit cycle is included in that commit
        sys_wen_i = 1'b1; sys_addr_i = 32'd4; sys_wdata_i = 32'h0000_0077; sys_sel_i = 4'b0001;
        commit_i = 1'b1;
        tick();
        sys_wen_i = 1'b0;
        commit_i = 1'b0;
        check("sh_commit_same", word_of(ctrl_o, 1), 32'h0000_0077);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
